int_square: RTL and testbench

- Multi-cycle shift-add squarer; the inverse operation of the team's ISR integer-square-root block.
- Takes a 32-bit root candidate and produces its exact 64-bit square.
- Uses the same start/done/result handshake style as ISR.
- Sits beside ISR in the datapath and in the bench as a golden re-squaring check (result*result vs value).

---
 rtl/int_square.sv | 97 +++++++++
 tb/tb_int_square.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/int_square.sv
// Multi-cycle shift-add squarer: result = value*value, one multiplier bit per cycle.
// Define INT_SQUARE_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module int_square #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   value,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     mplier_shr;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 accept;
    logic                 last;

    // The partial product always fits: value < 2^WIDTH, so the square fits in 2*WIDTH bits.
    assign acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_shr = mplier_q >> 1;

`ifdef INT_SQUARE_EARLY_TERM_EN
    assign last = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shr == '0);
`else
    assign last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mcand_q  <= {{WIDTH{1'b0}}, value};
                mplier_q <= value;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == CALC) begin
                acc_q    <= acc_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_shr;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last) begin
                    result_q <= acc_sum;
                end
            end
        end
    end

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q == CALC);

endmodule

// File: tb/tb_int_square.sv
// Directed self-checking bench for int_square: latency, handshake, reset and exact squares.
// Honours INT_SQUARE_EARLY_TERM_EN when computing the expected latency.
module tb_int_square;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic [63:0] result;
    logic        done;
    logic        busy;

    int total  = 0;
    int passed = 0;

    int_square #(.WIDTH(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .value  (value),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] v);
`ifdef INT_SQUARE_EARLY_TERM_EN
        int m = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) m = i;
        end
        return m + 1;
`else
        return 32;
`endif
    endfunction

    // Integer square root of a 64-bit value, the bench's stand-in for ISR.
    function automatic logic [31:0] isqrt64(input logic [63:0] x);
        logic [31:0] root;
        logic [31:0] trial;
        root = '0;
        for (int i = 31; i >= 0; i--) begin
            trial = root | (32'd1 << i);
            if ({32'b0, trial} * {32'b0, trial} <= x) root = trial;
        end
        return root;
    endfunction

    // Present start for exactly one rising edge; returns at the falling edge after acceptance.
    task automatic start_op(input logic [31:0] v);
        @(negedge clock);
        start = 1'b1;
        value = v;
        @(negedge clock);
        start = 1'b0;
        value = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] v, input logic [63:0] exp_res);
        int cyc;
        start_op(v);
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " done low"}, 64'(done), 64'd0);
        wait_done(cyc);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat(v)));
        check({tag, " result"}, result, exp_res);
        check({tag, " busy low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] rv;

        reset = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (2) @(negedge clock);
        check("reset result", result, 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset = 1'b1;

        run_op("0x1001", 32'h0000_1001, 64'h0000_0000_0100_2001);
        run_op("max", 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("zero", 32'h0, 64'h0);

        // A start pulse during CALC must not restart the operation.
        start_op(32'h0000_2345);
        repeat (4) @(negedge clock);
        start = 1'b1;
        value = 32'h10;
        @(negedge clock);
        start = 1'b0;
        check("ignored start busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("ignored start latency", 64'(cyc + 5), 64'(exp_lat(32'h2345)));
        check("ignored start result", result, 64'h0000_0000_04DB_F099);
        @(negedge clock);
        check("ignored start done holds", 64'(done), 64'd1);
        check("ignored start result holds", result, 64'h0000_0000_04DB_F099);

        // Restart from DONE: old result held until the new completion.
        run_op("0x1001 again", 32'h0000_1001, 64'h0000_0000_0100_2001);
        start_op(32'h3);
        check("restart done drops", 64'(done), 64'd0);
        check("restart result held", result, 64'h0000_0000_0100_2001);
        wait_done(cyc);
        check("restart latency", 64'(cyc), 64'(exp_lat(32'h3)));
        check("restart result", result, 64'h9);
        check("restart done", 64'(done), 64'd1);

        // Reset in the middle of CALC, with start also asserted: reset wins.
        start_op(32'h0123_4567);
        repeat (10) @(negedge clock);
        check("mid-calc busy", 64'(busy), 64'd1);
        reset = 1'b0;
        start = 1'b1;
        value = 32'h5;
        @(negedge clock);
        check("mid-calc reset busy", 64'(busy), 64'd0);
        check("mid-calc reset done", 64'(done), 64'd0);
        check("mid-calc reset result", result, 64'd0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        check("idle stays idle", 64'(busy), 64'd0);
        run_op("after reset 0x7", 32'h7, 64'h31);

        // Random operands: exact square and ISR round trip.
        for (int i = 0; i < 10; i++) begin
            rv = $urandom;
            run_op("random", rv, {32'b0, rv} * {32'b0, rv});
            check("isr round trip", 64'(isqrt64(result)), 64'(rv));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
